led_rate_scheduler: RTL and testbench



---
 rtl/led_sched_pkg.sv | 35 +++
 rtl/led_blink_divider.sv | 47 ++++
 rtl/led_rate_scheduler.sv | 87 ++++++++
 tb/tb_led_rate_scheduler.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/led_sched_pkg.sv
// Shared types and helpers for the LED blink-rate scheduler.
package led_sched_pkg;

    // Encoding chosen so that the state doubles as the phase output.
    typedef enum logic [1:0] {
        ST_PH0  = 2'd0,
        ST_PH1  = 2'd1,
        ST_PH2  = 2'd2,
        ST_IDLE = 2'd3
    } state_e;

    localparam logic [1:0] PHASE_IDLE = 2'd3;

    function automatic int unsigned half_for_phase(
        input logic [1:0]  ph,
        input int unsigned h0,
        input int unsigned h1,
        input int unsigned h2
    );
        case (ph)
            2'd0:    return h0;
            2'd1:    return h1;
            default: return h2;
        endcase
    endfunction

    function automatic state_e next_phase(input state_e s);
        case (s)
            ST_PH0:  return ST_PH1;
            ST_PH1:  return ST_PH2;
            default: return ST_PH0;
        endcase
    endfunction

endpackage

// File: rtl/led_blink_divider.sv
// Blink counter plus LED toggle flop; toggles once per half_period cycles.
module led_blink_divider #(
    parameter int unsigned CW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          off_i,
    input  logic [CW-1:0] half_period_i,
    output logic          led_o,
    output logic          toggle_tick_o
);

    logic [CW-1:0] cnt_q;
    logic          led_q;
    logic          tick_q;
    logic          wrap;

    assign wrap = (cnt_q == half_period_i - CW'(1));

    // clear restarts the count but keeps the LED level; off forces it dark.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            led_q  <= 1'b0;
            tick_q <= 1'b0;
        end else if (off_i) begin
            cnt_q  <= '0;
            led_q  <= 1'b0;
            tick_q <= 1'b0;
        end else if (clear_i) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else if (wrap) begin
            cnt_q  <= '0;
            led_q  <= ~led_q;
            tick_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_q + CW'(1);
            tick_q <= 1'b0;
        end
    end

    assign led_o         = led_q;
    assign toggle_tick_o = tick_q;

endmodule

// File: rtl/led_rate_scheduler.sv
// Sequences the LED blinker through three blink-rate phases with a fixed
// dwell per phase, plus enable, hold and manual-step control.
module led_rate_scheduler
    import led_sched_pkg::*;
#(
    parameter int unsigned HALF0 = 1250000,
    parameter int unsigned HALF1 = 2500000,
    parameter int unsigned HALF2 = 5000000,
    parameter int unsigned DWELL = 50000000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       enable_i,
    input  logic       hold_i,
    input  logic       step_i,
    output logic       led_o,
    output logic [1:0] phase_o,
    output logic       toggle_tick_o,
    output logic       phase_done_o
);

    localparam int unsigned M01  = (HALF0 > HALF1) ? HALF0 : HALF1;
    localparam int unsigned M23  = (HALF2 > DWELL) ? HALF2 : DWELL;
    localparam int unsigned MAXV = (M01 > M23) ? M01 : M23;
    localparam int unsigned CW   = (MAXV > 1) ? $clog2(MAXV) : 1;

    state_e        state_q, state_d;
    logic [CW-1:0] dwell_q, dwell_d;
    logic          done_q, done_d;
    logic          advance;
    logic [CW-1:0] half;

    // Step and dwell expiry in the same cycle collapse into one advance.
    assign advance = step_i || ((dwell_q == CW'(DWELL - 1)) && !hold_i);

    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        done_d  = 1'b0;
        if (state_q == ST_IDLE) begin
            if (enable_i) begin
                state_d = ST_PH0;
                dwell_d = '0;
                done_d  = 1'b1;
            end
        end else if (!enable_i) begin
            state_d = ST_IDLE;
            dwell_d = '0;
        end else if (advance) begin
            state_d = next_phase(state_q);
            dwell_d = '0;
            done_d  = 1'b1;
        end else if (!hold_i) begin
            dwell_d = dwell_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            dwell_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            done_q  <= done_d;
        end
    end

    assign half = CW'(half_for_phase(state_q, HALF0, HALF1, HALF2));

    // Every phase change restarts the divider so a faster phase never
    // inherits a count beyond its own terminal value.
    led_blink_divider #(.CW(CW)) u_div (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .clear_i       (done_d),
        .off_i         (state_d == ST_IDLE),
        .half_period_i (half),
        .led_o         (led_o),
        .toggle_tick_o (toggle_tick_o)
    );

    assign phase_o      = state_q;
    assign phase_done_o = done_q;

endmodule

// File: tb/tb_led_rate_scheduler.sv
// Scoreboard bench: expected tick/phase_done events are queued per phase and
// matched against every cycle the DUT pulses either output.
module tb_led_rate_scheduler;

    localparam int HALF0 = 2;
    localparam int HALF1 = 3;
    localparam int HALF2 = 5;
    localparam int DWELL = 20;

    typedef struct packed {
        int         cyc;
        logic       tick;
        logic       done;
        logic       led;
        logic [1:0] ph;
    } ev_t;

    logic       clk, rst, enable, hold, step;
    logic       led;
    logic [1:0] phase;
    logic       toggle_tick, phase_done;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    ev_t  sb[$];
    logic led_e;
    ev_t  mon_exp, mon_got;

    led_rate_scheduler #(
        .HALF0(HALF0), .HALF1(HALF1), .HALF2(HALF2), .DWELL(DWELL)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .enable_i      (enable),
        .hold_i        (hold),
        .step_i        (step),
        .led_o         (led),
        .phase_o       (phase),
        .toggle_tick_o (toggle_tick),
        .phase_done_o  (phase_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Phase entered at cycle p lasting len cycles: a phase_done event at p,
    // then a toggle every half cycles strictly before the phase ends.
    task automatic expect_phase(input int p, input logic [1:0] ph, input int half, input int len);
        sb.push_back('{cyc: p, tick: 1'b0, done: 1'b1, led: led_e, ph: ph});
        for (int m = 1; m * half < len; m++) begin
            led_e = ~led_e;
            sb.push_back('{cyc: p + m * half, tick: 1'b1, done: 1'b0, led: led_e, ph: ph});
        end
    endtask

    always @(negedge clk) begin
        if (toggle_tick === 1'b1 || phase_done === 1'b1) begin
            mon_got = '{cyc: cyc, tick: toggle_tick, done: phase_done, led: led, ph: phase};
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event cyc=%0d tick=%0b done=%0b led=%0b phase=%0d (none expected)",
                         cyc, toggle_tick, phase_done, led, phase);
            end else begin
                mon_exp = sb.pop_front();
                if (mon_got !== mon_exp) begin
                    n_fail++;
                    $display("FAIL event got cyc=%0d tick=%0b done=%0b led=%0b phase=%0d expected cyc=%0d tick=%0b done=%0b led=%0b phase=%0d",
                             mon_got.cyc, mon_got.tick, mon_got.done, mon_got.led, mon_got.ph,
                             mon_exp.cyc, mon_exp.tick, mon_exp.done, mon_exp.led, mon_exp.ph);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int p, r;
        rst = 1'b1; enable = 1'b0; hold = 1'b0; step = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_led", led, 0);
        chk("rst_phase", phase, 3);
        chk("rst_tick", toggle_tick, 0);
        chk("rst_done", phase_done, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_phase", phase, 3);

        // Free run through PH0, PH1, PH2, PH0.
        led_e = 1'b0;
        p = cyc + 1;
        enable = 1'b1;
        expect_phase(p, 2'd0, HALF0, DWELL); p += DWELL;
        expect_phase(p, 2'd1, HALF1, DWELL); p += DWELL;
        expect_phase(p, 2'd2, HALF2, DWELL); p += DWELL;
        expect_phase(p, 2'd0, HALF0, DWELL); p += DWELL;

        // PH1 with 30 held cycles stretches the phase by exactly 30.
        expect_phase(p, 2'd1, HALF1, DWELL + 30);
        wait_cyc(p + 5);  hold = 1'b1;
        wait_cyc(p + 25); chk("hold_phase", phase, 1);
        wait_cyc(p + 35); hold = 1'b0;
        p += DWELL + 30;

        // PH2, drop enable while led is lit.
        expect_phase(p, 2'd2, HALF2, 12);
        wait_cyc(p + 11); chk("pre_dis_led", led, 1);
        enable = 1'b0;
        wait_cyc(p + 12);
        chk("dis_led", led, 0);
        chk("dis_phase", phase, 3);
        chk("dis_tick", toggle_tick, 0);
        chk("dis_done", phase_done, 0);
        led_e = 1'b0;
        wait_cyc(p + 13); enable = 1'b1;
        p += 14;

        // Step in PH0 at dwell 5, then step on PH1's dwell expiry.
        expect_phase(p, 2'd0, HALF0, 6);
        wait_cyc(p + 5); step = 1'b1;
        wait_cyc(p + 6); step = 1'b0;
        p += 6;
        expect_phase(p, 2'd1, HALF1, DWELL);
        wait_cyc(p + DWELL - 1); step = 1'b1;
        wait_cyc(p + DWELL);     step = 1'b0;
        p += DWELL;
        expect_phase(p, 2'd2, HALF2, 2);
        wait_cyc(p + 1); step = 1'b1;
        wait_cyc(p + 2); step = 1'b0;
        p += 2;
        expect_phase(p, 2'd0, HALF0, 2);
        wait_cyc(p + 1); step = 1'b1;
        wait_cyc(p + 2); step = 1'b0;
        p += 2;

        // Asynchronous reset in the middle of PH1.
        expect_phase(p, 2'd1, HALF1, 5);
        wait_cyc(p + 3); chk("pre_rst_led", led, 1);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk("arst_led", led, 0);
        chk("arst_phase", phase, 3);
        chk("arst_tick", toggle_tick, 0);
        chk("arst_done", phase_done, 0);
        led_e = 1'b0;
        wait_cyc(p + 5);
        r = cyc;
        expect_phase(r + 1, 2'd0, HALF0, 5);
        rst = 1'b0;
        wait_cyc(r + 5); enable = 1'b0;
        wait_cyc(r + 10);
        chk("final_phase", phase, 3);
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
